// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the interrupt controller.
//   RET_OPCODE  : opcode that ends an interrupt service routine
//   ISR_VECTOR  : PC value the jump control block loads on an interrupt grant
//   irq_state_e : interrupt handshake FSM states (2-bit binary encoding)
package cpu_pkg;

    localparam logic [5:0]  RET_OPCODE = 6'b010000;
    localparam logic [15:0] ISR_VECTOR = 16'hF000;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant   = 2'd1,
        StService = 2'd2,
        StDone    = 2'd3
    } irq_state_e;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: the lowest-index asserted request wins.
// Ports:
//   req_i    : request vector
//   valid_o  : at least one request asserted
//   idx_o    : index of the winning request (0 when none)
//   onehot_o : one-hot mask of the winning request (0 when none)
module irq_priority_encoder #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    idx_o,
    output logic [NUM_SRC-1:0] onehot_o
);

    // Scan from the top down so the lowest asserted index is the last write.
    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o     = 1'b1;
                idx_o       = ID_W'(i);
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Initiator side of the CPU interrupt handshake. Rising edges on irq_src are
// latched as pending; the highest-priority unmasked pending source is granted
// as a one-cycle 'interrupt' pulse to the jump control block (PC -> ISR_VECTOR).
// No further grants until the ISR's return opcode is seen. Single level only.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   irq_src    : request lines; a rising edge raises a request
//   irq_mask   : 1 = source masked (still latched as pending, never granted)
//   irq_en     : global enable; 0 blocks new grants only
//   op         : opcode of the currently executing instruction
//   interrupt  : one-cycle grant pulse (registered)
//   irq_id     : index of the source in service, held until the next grant
//   in_service : high from the grant cycle through the ret cycle
//   pending    : latched, not-yet-granted requests
module interrupt_controller #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned ID_W       = 2,
    parameter logic [5:0]  RET_OPCODE = cpu_pkg::RET_OPCODE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               irq_en,
    input  logic [5:0]         op,
    output logic               interrupt,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending
);

    import cpu_pkg::*;

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic               interrupt_q;
    logic               in_service_q;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] win_oh;
    logic [NUM_SRC-1:0] grant_oh;
    logic [ID_W-1:0]    win_id;
    logic               win_valid;

    assign rise = irq_src & ~src_q;
    assign elig = pending_q & ~irq_mask & {NUM_SRC{irq_en}};

    irq_priority_encoder #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio (
        .req_i    (elig),
        .valid_o  (win_valid),
        .idx_o    (win_id),
        .onehot_o (win_oh)
    );

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        grant_oh = '0;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d  = StGrant;
                    irq_id_d = win_id;
                    grant_oh = win_oh;
                end
            end
            StGrant:   state_d = StService;
            // Return opcode during the grant cycle itself is not the ISR's ret.
            StService: if (op == RET_OPCODE) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        // A new rise on the granted source wins over the clear.
        pending_d = (pending_q & ~grant_oh) | rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            src_q        <= '0;
            pending_q    <= '0;
            irq_id_q     <= '0;
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= irq_src;
            pending_q    <= pending_d;
            irq_id_q     <= irq_id_d;
            interrupt_q  <= (state_d == StGrant);
            in_service_q <= (state_d == StGrant) || (state_d == StService);
        end
    end

    assign interrupt  = interrupt_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus a
// randomized run, all compared cycle by cycle against a timeline model.
module tb_interrupt_controller;

    localparam int unsigned NSRC = 4;
    localparam int unsigned IDW  = 2;
    localparam logic [5:0]  RET  = 6'b010000;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] irq_src;
    logic [NSRC-1:0] irq_mask;
    logic            irq_en;
    logic [5:0]      op;
    logic            interrupt;
    logic [IDW-1:0]  irq_id;
    logic            in_service;
    logic [NSRC-1:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    interrupt_controller #(
        .NUM_SRC    (NSRC),
        .ID_W       (IDW),
        .RET_OPCODE (RET)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .irq_mask   (irq_mask),
        .irq_en     (irq_en),
        .op         (op),
        .interrupt  (interrupt),
        .irq_id     (irq_id),
        .in_service (in_service),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    // Reference model, described as an ISR timeline rather than FSM states:
    //   m_busy  : an ISR is in progress (grant cycle through ret cycle)
    //   m_pulse : this is the first cycle of the ISR (the grant pulse)
    //   m_cool  : cycles still to wait after a ret before a new grant may be decided
    logic [NSRC-1:0] m_pend;
    logic [NSRC-1:0] m_prev;
    logic [IDW-1:0]  m_id;
    bit              m_busy;
    bit              m_pulse;
    int              m_cool;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_prev  = '0;
        m_id    = '0;
        m_busy  = 1'b0;
        m_pulse = 1'b0;
        m_cool  = 0;
    endtask

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic model_advance();
        logic [NSRC-1:0] rise;
        logic [NSRC-1:0] elig;
        bit              granted;
        if (!reset) begin
            model_reset();
            return;
        end
        rise    = irq_src & ~m_prev;
        m_prev  = irq_src;
        elig    = m_pend & ~irq_mask & {NSRC{irq_en}};
        granted = 1'b0;
        m_pend  = m_pend | rise;
        if (m_busy) begin
            if (!m_pulse && op == RET) begin
                m_busy = 1'b0;
                m_cool = 1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            for (int i = 0; i < int'(NSRC); i++) begin
                if (!granted && elig[i]) begin
                    granted   = 1'b1;
                    m_id      = IDW'(i);
                    m_pend[i] = rise[i];
                end
            end
        end
        if (granted) m_busy = 1'b1;
        m_pulse = granted;
    endtask

    task automatic check_outputs();
        check_eq("interrupt", 32'(interrupt), 32'(m_pulse));
        check_eq("irq_id", 32'(irq_id), 32'(m_id));
        check_eq("in_service", 32'(in_service), 32'(m_busy));
        check_eq("pending", 32'(pending), 32'(m_pend));
    endtask

    // Called at a falling edge: check current outputs, apply inputs for the
    // next rising edge, advance the model, then move to the next falling edge.
    task automatic step(input logic [NSRC-1:0] src, input logic [NSRC-1:0] mask,
                        input logic en, input logic [5:0] opv);
        check_outputs();
        irq_src  = src;
        irq_mask = mask;
        irq_en   = en;
        op       = opv;
        model_advance();
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b0;
        irq_src  = '0;
        irq_mask = '0;
        irq_en   = 1'b1;
        op       = '0;
        model_reset();
        @(negedge clk);

        // 1: requests toggling while reset is held have no effect.
        for (int i = 0; i < 4; i++) begin
            step(i[0] ? 4'b0000 : 4'b1111, 4'b0000, 1'b1, 6'h00);
            check_eq("t1_int", 32'(interrupt), 32'd0);
            check_eq("t1_pend", 32'(pending), 32'd0);
            check_eq("t1_insvc", 32'(in_service), 32'd0);
        end
        irq_src = '0;
        @(negedge clk);
        reset = 1'b1;
        step(4'b0000, 4'b0000, 1'b1, 6'h00);

        // 2: single rise on source 2; pulse two cycles after the rise.
        step(4'b0100, 4'b0000, 1'b1, 6'h00);
        check_eq("t2_pend_vis", 32'(pending), 32'h4);
        check_eq("t2_no_pulse", 32'(interrupt), 32'd0);
        step(4'b0100, 4'b0000, 1'b1, 6'h00);
        check_eq("t2_pulse", 32'(interrupt), 32'd1);
        check_eq("t2_id", 32'(irq_id), 32'd2);
        check_eq("t2_pend_clr", 32'(pending), 32'h0);
        step(4'b0100, 4'b0000, 1'b1, 6'h00);
        check_eq("t2_one_cycle", 32'(interrupt), 32'd0);
        check_eq("t2_insvc", 32'(in_service), 32'd1);
        step(4'b0000, 4'b0000, 1'b1, RET);
        check_eq("t2_done", 32'(in_service), 32'd0);
        step(4'b0000, 4'b0000, 1'b1, 6'h00);
        step(4'b0000, 4'b0000, 1'b1, RET);  // ret while idle is ignored
        check_eq("t2_idle_ret", 32'(in_service), 32'd0);

        // 3: two simultaneous rises; lower index first, second exactly 4 cycles later.
        step(4'b1010, 4'b0000, 1'b1, 6'h00);
        step(4'b1010, 4'b0000, 1'b1, 6'h00);
        check_eq("t3_id1", 32'(irq_id), 32'd1);
        check_eq("t3_pend", 32'(pending), 32'h8);
        step(4'b1010, 4'b0000, 1'b1, 6'h00);
        step(4'b1010, 4'b0000, 1'b1, RET);
        step(4'b1010, 4'b0000, 1'b1, 6'h00);
        step(4'b1010, 4'b0000, 1'b1, 6'h00);
        check_eq("t3_pulse2", 32'(interrupt), 32'd1);
        check_eq("t3_id3", 32'(irq_id), 32'd3);
        step(4'b0000, 4'b0000, 1'b1, 6'h00);
        step(4'b0000, 4'b0000, 1'b1, RET);
        step(4'b0000, 4'b0000, 1'b1, 6'h00);

        // 4: masked source is latched but not granted until the mask clears.
        step(4'b0001, 4'b0001, 1'b1, 6'h00);
        step(4'b0001, 4'b0001, 1'b1, 6'h00);
        step(4'b0001, 4'b0001, 1'b1, 6'h00);
        check_eq("t4_pend", 32'(pending), 32'h1);
        check_eq("t4_no_pulse", 32'(interrupt), 32'd0);
        step(4'b0001, 4'b0000, 1'b1, 6'h00);
        check_eq("t4_pulse", 32'(interrupt), 32'd1);
        check_eq("t4_id0", 32'(irq_id), 32'd0);
        step(4'b0001, 4'b0000, 1'b1, 6'h00);

        // 5: ret and a new rise in the same cycle; pulse 3 cycles after the ret.
        step(4'b0011, 4'b0000, 1'b1, RET);
        check_eq("t5_done", 32'(in_service), 32'd0);
        check_eq("t5_pend", 32'(pending), 32'h2);
        step(4'b0011, 4'b0000, 1'b1, 6'h00);
        check_eq("t5_idle", 32'(interrupt), 32'd0);
        step(4'b0011, 4'b0000, 1'b1, 6'h00);
        check_eq("t5_pulse", 32'(interrupt), 32'd1);
        check_eq("t5_id1", 32'(irq_id), 32'd1);

        // 6: async reset during service with a request pending.
        step(4'b0111, 4'b0000, 1'b1, 6'h00);
        step(4'b0111, 4'b0000, 1'b1, 6'h00);
        check_eq("t6_pend", 32'(pending), 32'h4);
        #2 reset = 1'b0;
        #1;
        check_eq("t6_async_int", 32'(interrupt), 32'd0);
        check_eq("t6_async_svc", 32'(in_service), 32'd0);
        check_eq("t6_async_pend", 32'(pending), 32'd0);
        check_eq("t6_async_id", 32'(irq_id), 32'd0);
        model_reset();
        irq_src = '0;
        @(negedge clk);
        step(4'b0000, 4'b0000, 1'b1, 6'h00);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(4'b0000, 4'b0000, 1'b1, 6'h00);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [NSRC-1:0] s;
            logic [NSRC-1:0] m;
            logic [5:0]      o;
            s = irq_src;
            m = '0;
            for (int b = 0; b < int'(NSRC); b++) begin
                if ($urandom_range(0, 3) == 0) s[b] = ~s[b];
                if ($urandom_range(0, 7) == 0) m[b] = 1'b1;
            end
            o = ($urandom_range(0, 3) == 0) ? RET : 6'($urandom);
            step(s, m, ($urandom_range(0, 9) != 0), o);
        end
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
